// File: rtl/vga_rx.sv
// vga_rx: locks onto an incoming VGA stream, recovers active-region pixel
// coordinates and colour, and reports and counts every loss of lock.
module vga_rx #(
  parameter int HPIXELS = 800,
  parameter int VLINES  = 521,
  parameter int HBP     = 144,
  parameter int HFP     = 784,
  parameter int VBP     = 31,
  parameter int VFP     = 511
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] red,
  input  logic [2:0] green,
  input  logic [1:0] blue,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic [7:0] pix_rgb,
  output logic       pix_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err,
  output logic [7:0] err_cnt
);

  localparam logic [9:0] L_CMAX  = 10'd1023;
  localparam logic [9:0] L_HLAST = 10'(HPIXELS - 1);
  localparam logic [9:0] L_VLAST = 10'(VLINES - 1);
  localparam logic [9:0] L_HBP   = 10'(HBP);
  localparam logic [9:0] L_HFP   = 10'(HFP);
  localparam logic [9:0] L_VBP   = 10'(VBP);
  localparam logic [9:0] L_VFP   = 10'(VFP);

  typedef enum logic [1:0] {S_HUNT, S_CHECK, S_LOCKED} state_t;

  state_t     r_state;
  logic       r_hs, r_hs_d, r_vs, r_vs_d;
  logic [7:0] r_rgb;
  logic [9:0] r_h, r_v;
  logic       r_check_bad;
  logic [9:0] r_pix_x;
  logic [8:0] r_pix_y;
  logic [7:0] r_pix_rgb;
  logic       r_pix_valid, r_frame_start, r_locked, r_sync_err;
  logic [7:0] r_err_cnt;

  logic       w_hs_fall, w_vs_fall;
  logic [9:0] w_h, w_v;
  logic       w_period_bad, w_frame_bad, w_timeout, w_mismatch, w_active;

  // Syncs idle high, so the delayed copies reset high: a sender that starts
  // a frame right after reset release still produces a detectable edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_hs   <= 1'b1;
      r_hs_d <= 1'b1;
      r_vs   <= 1'b1;
      r_vs_d <= 1'b1;
      r_rgb  <= '0;
      r_h    <= '0;
      r_v    <= '0;
    end else begin
      r_hs   <= hsync;
      r_hs_d <= r_hs;
      r_vs   <= vsync;
      r_vs_d <= r_vs;
      r_rgb  <= {red, green, blue};
      r_h    <= w_h;
      r_v    <= w_v;
    end
  end

  assign w_hs_fall = r_hs_d & ~r_hs;
  assign w_vs_fall = r_vs_d & ~r_vs;

  // w_h/w_v are the sender position of the colour currently held in r_rgb.
  always_comb begin
    w_h = (r_h == L_CMAX) ? L_CMAX : r_h + 10'd1;
    if (w_hs_fall) w_h = '0;
    w_v = r_v;
    if (w_hs_fall) begin
      if (w_vs_fall)            w_v = '0;
      else if (r_v != L_CMAX)   w_v = r_v + 10'd1;
    end
  end

  assign w_period_bad = w_hs_fall && (r_h != L_HLAST);
  assign w_frame_bad  = w_vs_fall && (!w_hs_fall || (r_v != L_VLAST));
  assign w_timeout    = !w_hs_fall && (w_h == L_CMAX);
  assign w_mismatch   = (r_state == S_LOCKED) && (w_period_bad || w_frame_bad || w_timeout);
  assign w_active     = (r_state == S_LOCKED) && !w_mismatch &&
                        (w_h >= L_HBP) && (w_h < L_HFP) &&
                        (w_v >= L_VBP) && (w_v < L_VFP);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state       <= S_HUNT;
      r_check_bad   <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_rgb     <= '0;
      r_pix_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_locked      <= 1'b0;
      r_sync_err    <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_sync_err    <= 1'b0;
      r_pix_valid   <= w_active;
      r_frame_start <= w_active && (w_h == L_HBP) && (w_v == L_VBP);
      if (w_active) begin
        r_pix_x   <= w_h - L_HBP;
        r_pix_y   <= 9'(w_v - L_VBP);
        r_pix_rgb <= r_rgb;
      end
      case (r_state)
        S_HUNT: begin
          if (w_vs_fall && w_hs_fall) begin
            r_state     <= S_CHECK;
            r_check_bad <= 1'b0;
          end
        end
        S_CHECK: begin
          if (w_vs_fall) begin
            if (w_hs_fall && (r_v == L_VLAST) && !r_check_bad && !w_period_bad) begin
              r_state  <= S_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state <= S_HUNT;
            end
          end else if (w_period_bad) begin
            r_check_bad <= 1'b1;
          end
        end
        S_LOCKED: begin
          if (w_mismatch) begin
            r_state    <= S_HUNT;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
        default: begin
          r_state  <= S_HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign pix_rgb     = r_pix_rgb;
  assign pix_valid   = r_pix_valid;
  assign frame_start = r_frame_start;
  assign locked      = r_locked;
  assign sync_err    = r_sync_err;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx on a shrunken 16x6 raster: a sender model drives
// timing, a scoreboard predicts every valid pixel and all other cycles must be idle.
module tb_vga_rx;

  localparam int HP = 16;
  localparam int VL = 6;
  localparam int HB = 4;
  localparam int HF = 14;
  localparam int VB = 1;
  localparam int VF = 5;

  logic       clk;
  logic       clr;
  logic       hsync, vsync;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [7:0] pix_rgb;
  logic       pix_valid, frame_start, locked, sync_err;
  logic [7:0] err_cnt;

  typedef struct {
    int         due;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] rgb;
    logic       fs;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         err_pulses = 0;
  int         valid_seen = 0;
  int         last_edge = 0;
  logic [9:0] last_x = '0;
  logic [8:0] last_y = '0;
  logic [7:0] last_rgb = '0;
  exp_t       mon_e;

  vga_rx #(
    .HPIXELS(HP), .VLINES(VL), .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF)
  ) dut (
    .clk(clk), .clr(clr), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .pix_valid(pix_valid), .frame_start(frame_start),
    .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Sender: hsync low for h<2, vsync low for all of line 0, colour = h in the active area.
  task automatic drive_tick(input int h, input int v, input bit push_en);
    logic [7:0] col;
    bit         act;
    exp_t       e;
    @(posedge clk);
    #1;
    hsync = (h < 2) ? 1'b0 : 1'b1;
    vsync = (v == 0) ? 1'b0 : 1'b1;
    act   = (h >= HB) && (h < HF) && (v >= VB) && (v < VF);
    col   = act ? 8'(h) : 8'h00;
    {red, green, blue} = col;
    if (h == 0) last_edge = cyc;
    if (push_en && act) begin
      e.due = cyc + 2;
      e.x   = 10'(h - HB);
      e.y   = 9'(v - VB);
      e.rgb = col;
      e.fs  = (h == HB) && (v == VB);
      sb.push_back(e);
    end
  endtask

  task automatic idle_tick();
    @(posedge clk);
    #1;
    hsync = 1'b1;
    vsync = 1'b1;
    {red, green, blue} = 8'h00;
  endtask

  task automatic drive_line(input int v, input int len, input bit push_en);
    for (int h = 0; h < len; h++) drive_tick(h, v, push_en);
  endtask

  task automatic drive_frame(input bit push_en);
    for (int v = 0; v < VL; v++) drive_line(v, HP, push_en);
  endtask

  // Monitor: a due scoreboard entry must appear as a valid pixel, any other cycle must be idle and holding.
  always @(negedge clk) begin
    if (clr) begin
      last_x   = '0;
      last_y   = '0;
      last_rgb = '0;
    end else begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        chk("pixel", {35'd0, pix_valid, frame_start, pix_x, pix_y, pix_rgb},
                     {35'd0, 1'b1, mon_e.fs, mon_e.x, mon_e.y, mon_e.rgb});
        last_x   = mon_e.x;
        last_y   = mon_e.y;
        last_rgb = mon_e.rgb;
      end else begin
        chk("idle_hold", {35'd0, pix_valid, frame_start, pix_x, pix_y, pix_rgb},
                         {35'd0, 2'b00, last_x, last_y, last_rgb});
      end
      if (pix_valid === 1'b1) valid_seen++;
      if (sync_err === 1'b1) err_pulses++;
    end
  end

  int p0, v0, e_cyc;

  initial begin
    clr = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    red = '0;
    green = '0;
    blue = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {25'd0, pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, sync_err, err_cnt}, 64'd0);
    #1 clr = 1'b0;

    // Lock: first vsync edge starts CHECK, second locks.
    drive_frame(1'b0);
    @(negedge clk); chk("check_frame_unlocked", locked, 0);
    drive_tick(0, 0, 1'b1); @(negedge clk); chk("lock_edge_c0", locked, 0);
    drive_tick(1, 0, 1'b1); @(negedge clk); chk("lock_edge_c1", locked, 0);
    drive_tick(2, 0, 1'b1); @(negedge clk); chk("lock_edge_c2", locked, 1);
    for (int h = 3; h < HP; h++) drive_tick(h, 0, 1'b1);
    v0 = valid_seen;
    for (int v = 1; v < VL; v++) drive_line(v, HP, 1'b1);
    @(negedge clk); chk("valid_per_frame", valid_seen - v0, (HF - HB) * (VF - VB));

    // Line glitch: line 0 one clock short.
    p0 = err_pulses;
    drive_line(0, HP - 1, 1'b0);
    for (int v = 1; v < VL; v++) drive_line(v, HP, 1'b0);
    @(negedge clk);
    chk("glitch_pulses", err_pulses - p0, 1);
    chk("glitch_unlocked", locked, 0);
    chk("glitch_err_cnt", err_cnt, 1);
    drive_frame(1'b0);
    @(negedge clk); chk("glitch_check_frame", locked, 0);
    drive_frame(1'b1);
    @(negedge clk); chk("glitch_relock", locked, 1);

    // Timeout: hsync held high after line 1 starts.
    drive_line(0, HP, 1'b1);
    drive_line(1, HP, 1'b1);
    e_cyc = last_edge;
    while (cyc < e_cyc + 1024) idle_tick();
    @(negedge clk); chk("timeout_early", sync_err, 0);
    idle_tick();
    @(negedge clk);
    chk("timeout_fire", sync_err, 1);
    chk("timeout_unlocked", locked, 0);
    idle_tick();
    @(negedge clk);
    chk("timeout_after", {sync_err, pix_valid}, 0);
    chk("timeout_err_cnt", err_cnt, 2);
    drive_frame(1'b0);
    drive_frame(1'b1);
    @(negedge clk); chk("timeout_relock", locked, 1);

    // Reset mid-frame at sender (8,3).
    p0 = err_pulses;
    drive_line(0, HP, 1'b1);
    drive_line(1, HP, 1'b1);
    drive_line(2, HP, 1'b1);
    for (int h = 0; h <= 8; h++) drive_tick(h, 3, 1'b1);
    #2 clr = 1'b1;
    sb.delete();
    hsync = 1'b1;
    vsync = 1'b1;
    {red, green, blue} = 8'h00;
    #1 chk("async_reset", {25'd0, pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, sync_err, err_cnt}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_held", {25'd0, pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, sync_err, err_cnt}, 64'd0);
    #1 clr = 1'b0;
    drive_frame(1'b0);
    @(negedge clk);
    chk("reset_needs_check", locked, 0);
    chk("reset_no_sync_err", err_pulses - p0, 0);
    drive_frame(1'b1);
    @(negedge clk); chk("reset_relock", locked, 1);

    // Saturation: 300 glitches, one per relock.
    p0 = err_pulses;
    for (int i = 0; i < 300; i++) begin
      drive_frame(i == 0);
      drive_line(0, HP - 1, 1'b0);
      drive_line(1, HP, 1'b0);
      if (i == 253) begin
        @(negedge clk); chk("err_cnt_254", err_cnt, 254);
      end
    end
    @(negedge clk);
    chk("err_cnt_saturated", err_cnt, 255);
    chk("sat_pulses", err_pulses - p0, 300);
    chk("sat_unlocked", locked, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rx.md
VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 Parameter HPIXELS, default 800, clocks per line.
REQ-002 Parameter VLINES, default 521, lines per frame.
REQ-003 Parameter HBP, default 144, first active clock after hsync falling edge.
REQ-004 Parameter HFP, default 784, first inactive clock after the active region.
REQ-005 Parameter VBP, default 31, first active line after vsync falling edge.
REQ-006 Parameter VFP, default 511, first inactive line after the active region.
REQ-007 clk, input, 1, pixel clock, 25 MHz, same clock as the sender.
REQ-008 clr, input, 1, reset: one clock; reset is asynchronous and active-high.
REQ-009 hsync, input, 1, horizontal sync, active low.
REQ-010 vsync, input, 1, vertical sync, active low.
REQ-011 red, input, 3; green, input, 3; blue, input, 2; incoming colour.
REQ-012 pix_x, output, 10, active column, 0..639.
REQ-013 pix_y, output, 9, active row, 0..479.
REQ-014 pix_rgb, output, 8, {red,green,blue} of the captured pixel.
REQ-015 pix_valid, output, 1, pix_x/pix_y/pix_rgb hold an active pixel.
REQ-016 frame_start, output, 1, one-cycle pulse with pixel (0,0).
REQ-017 locked, output, 1, receiver is locked to incoming timing.
REQ-018 sync_err, output, 1, one-cycle pulse on loss of lock.
REQ-019 err_cnt, output, 8, saturating count of sync_err pulses.

Function
REQ-020 All inputs SHALL be registered once; edge detection SHALL use that registered copy and its one-cycle-delayed copy.
REQ-021 An hsync falling edge SHALL define h=0. The internal h counter SHALL count clocks from that edge.
REQ-022 A vsync falling edge that coincides with an hsync falling edge SHALL define v=0. The v counter SHALL increment on each hsync falling edge.
REQ-023 A pixel driven on the inputs at sender position (h,v) SHALL appear on the outputs exactly 2 clocks later, with pix_x=h-HBP and pix_y=v-VBP.
REQ-024 pix_valid=1 iff locked=1, HBP<=h<HFP and VBP<=v<VFP. pix_x, pix_y and pix_rgb SHALL hold their last value while pix_valid=0.
REQ-025 frame_start SHALL be 1 only in the cycle where pix_valid=1, pix_x=0 and pix_y=0.
REQ-026 The lock FSM SHALL have three states: HUNT, CHECK and LOCKED.
REQ-027 HUNT: on a vsync falling edge, go to CHECK and clear the counters.
REQ-028 CHECK: on the next vsync falling edge, go to LOCKED if every hsync period was exactly HPIXELS and exactly VLINES hsync edges occurred; otherwise return to HUNT with no sync_err.
REQ-029 LOCKED is a mismatch when any of the following occurs:
- an hsync period is not HPIXELS;
- a vsync falling edge arrives with v not equal to VLINES-1 at the edge;
- the h counter reaches 1023 without an hsync edge (timeout).
REQ-030 On a LOCKED mismatch, pulse sync_err for one cycle, go to HUNT, and drop locked and pix_valid in that same cycle.
REQ-031 locked SHALL be 1 exactly in state LOCKED.
REQ-032 The h counter SHALL saturate at 1023. The v counter SHALL saturate at 1023.
REQ-033 err_cnt SHALL increment on each sync_err and SHALL hold at 255.
REQ-034 A vsync falling edge without a coincident hsync edge SHALL be a mismatch in LOCKED and SHALL be ignored in HUNT.

Reset
REQ-035 While clr=1, asynchronously and independent of clk:
- the FSM SHALL be in HUNT;
- pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, sync_err and err_cnt SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL abandon the frame. After release, at least one full CHECK frame SHALL be required before locked=1.

Verification
REQ-037 Lock: drive standard 800x521 timing from clr release. locked=1 at the second vsync falling edge. The first frame_start comes 2 clocks after sender position (144,31) of the following frame.
REQ-038 Pixel map: sender drives colour = h[7:0] in the active region. pix_rgb=0x90 at pix_x=0. pix_valid is high for exactly 640 clocks per line and 480 lines per frame.
REQ-039 Line glitch: while locked, shorten one line to 799 clocks. sync_err pulses once, locked falls, err_cnt=1, and relock occurs after two more good vsync edges.
REQ-040 Timeout: while locked, hold hsync high. sync_err fires when h reaches 1023, and pix_valid=0 thereafter.
REQ-041 Reset mid-frame: assert clr at sender (400,200) for 3 clocks. All outputs read 0 immediately with no clk edge needed, and there is no sync_err.
REQ-042 Saturation: inject 300 line glitches. err_cnt stops at 255 and does not wrap.
